// File: rtl/temporal_encoder_arbiter.sv
// Round-robin arbiter that shares one temporal encoder among NUM_REQ modality streams.
// A grant keeps one requester for up to BURST_LEN transactions; changing requester clears n-gram history.
`ifndef HV_DIMENSION
`define HV_DIMENSION 32
`endif

module temporal_encoder_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int HV_DIM    = `HV_DIMENSION,
  parameter int BURST_LEN = 4
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RI,
  input  logic [NUM_REQ-1:0]        ValidIn_SI,
  output logic [NUM_REQ-1:0]        ReadyOut_SO,
  input  logic [NUM_REQ*HV_DIM-1:0] HypervectorIn_DI,
  output logic                      EncValid_SO,
  input  logic                      EncReady_SI,
  output logic [HV_DIM-1:0]         EncHypervector_DO,
  output logic                      EncClear_SO,
  input  logic                      EncResultValid_SI,
  output logic                      EncResultReady_SO,
  input  logic [HV_DIM-1:0]         EncResult_DI,
  output logic                      ValidOut_SO,
  input  logic                      ReadyIn_SI,
  output logic [HV_DIM-1:0]         HypervectorOut_DO,
  output logic [2:0]                ChannelOut_DO
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    SEND    = 3'd2,
    WAIT    = 3'd3,
    DELIVER = 3'd4
  } state_e;

  state_e            state_r, state_s;
  logic [GW-1:0]     grant_r, grant_s;
  logic [GW-1:0]     last_grant_r, last_grant_s;
  logic              last_valid_r, last_valid_s;
  logic [CW-1:0]     burst_r, burst_s;
  logic              capture_s;
  logic [HV_DIM-1:0] hv_out_r;
  logic [2:0]        chan_r;

  logic [NUM_REQ-1:0] ready_s;
  logic               enc_valid_s;
  logic [HV_DIM-1:0]  enc_hv_s;
  logic               enc_clear_s;
  logic               res_ready_s;
  logic               valid_out_s;

  // First valid requester at or after LastGrant+1 (index 0 when no grant has been recorded yet).
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [GW-1:0]      last,
                                            input logic               last_ok);
    logic [GW-1:0] pick;
    int            start;
    int            idx;
    pick  = {GW{1'b0}};
    start = last_ok ? ((int'(last) + 1) % NUM_REQ) : 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx  = (start + i) % NUM_REQ;
      pick = req[idx] ? GW'(idx) : pick;
    end
    return pick;
  endfunction

  // Next-state and handshake outputs of the arbitration FSM.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    last_valid_s = last_valid_r;
    burst_s      = burst_r;
    capture_s    = 1'b0;
    ready_s      = {NUM_REQ{1'b0}};
    enc_valid_s  = 1'b0;
    enc_hv_s     = {HV_DIM{1'b0}};
    enc_clear_s  = 1'b0;
    res_ready_s  = 1'b0;
    valid_out_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|ValidIn_SI) begin
          grant_s = rr_pick(ValidIn_SI, last_grant_r, last_valid_r);
          burst_s = {CW{1'b0}};
          if (!last_valid_r || (grant_s != last_grant_r)) begin
            state_s = CLEAR;
          end else begin
            state_s = SEND;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        enc_clear_s  = 1'b1;
        last_grant_s = grant_r;
        last_valid_s = 1'b1;
        state_s      = SEND;
      end
      SEND: begin
        enc_valid_s      = ValidIn_SI[grant_r];
        enc_hv_s         = HypervectorIn_DI[int'(grant_r)*HV_DIM +: HV_DIM];
        ready_s[grant_r] = EncReady_SI;
        if (ValidIn_SI[grant_r] && EncReady_SI) begin
          burst_s = burst_r + CW'(1);
          state_s = WAIT;
        end else if (!ValidIn_SI[grant_r]) begin
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      WAIT: begin
        res_ready_s = 1'b1;
        if (EncResultValid_SI) begin
          capture_s = 1'b1;
          state_s   = DELIVER;
        end else begin
          state_s = WAIT;
        end
      end
      DELIVER: begin
        valid_out_s = 1'b1;
        if (ReadyIn_SI) begin
          // Burst continues on the same grant without a history clear.
          if ((burst_r == CW'(BURST_LEN)) || !ValidIn_SI[grant_r]) begin
            state_s = IDLE;
          end else begin
            state_s = SEND;
          end
        end else begin
          state_s = DELIVER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, grant bookkeeping and the result holding register.
  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_r      <= IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= {GW{1'b0}};
      last_valid_r <= 1'b0;
      burst_r      <= {CW{1'b0}};
      hv_out_r     <= {HV_DIM{1'b0}};
      chan_r       <= 3'd0;
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      last_valid_r <= last_valid_s;
      burst_r      <= burst_s;
      if (capture_s) begin
        hv_out_r <= EncResult_DI;
        chan_r   <= 3'(grant_r);
      end
    end
  end

  assign ReadyOut_SO       = ready_s;
  assign EncValid_SO       = enc_valid_s;
  assign EncHypervector_DO = enc_hv_s;
  assign EncClear_SO       = enc_clear_s;
  assign EncResultReady_SO = res_ready_s;
  assign ValidOut_SO       = valid_out_s;
  assign HypervectorOut_DO = hv_out_r;
  assign ChannelOut_DO     = chan_r;

endmodule

// File: doc/temporal_encoder_arbiter.md
TEMPORAL_ENCODER_ARBITER -- requirements
Module: temporal_encoder_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of modality requesters sharing one temporal encoder; SHALL be 2..8.
REQ-002 Parameter HV_DIM, default `HV_DIMENSION: hypervector width in bits.
REQ-003 Parameter BURST_LEN, default 4: maximum encoder transactions per grant; SHALL be >= 1.
REQ-004 Clk_CI  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset_RI  in  1  reset, asynchronous and active-high.
REQ-006 ValidIn_SI  in  NUM_REQ  per-requester valid.
REQ-007 ReadyOut_SO  out  NUM_REQ  per-requester ready.
REQ-008 HypervectorIn_DI  in  NUM_REQ*HV_DIM  requester hypervectors; requester k occupies bits [k*HV_DIM +: HV_DIM].
REQ-009 EncValid_SO  out  1  valid toward the encoder.
REQ-010 EncReady_SI  in  1  encoder ready.
REQ-011 EncHypervector_DO  out  HV_DIM  hypervector toward the encoder.
REQ-012 EncClear_SO  out  1  one-cycle pulse that clears the encoder n-gram history.
REQ-013 EncResultValid_SI  in  1  encoder result valid.
REQ-014 EncResultReady_SO  out  1  ready for the encoder result.
REQ-015 EncResult_DI  in  HV_DIM  encoder result hypervector.
REQ-016 ValidOut_SO  out  1  tagged result valid downstream.
REQ-017 ReadyIn_SI  in  1  downstream ready.
REQ-018 HypervectorOut_DO  out  HV_DIM  registered encoder result.
REQ-019 ChannelOut_DO  out  3  index of the requester that owns HypervectorOut_DO.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, CLEAR, SEND, WAIT and DELIVER.
REQ-021 IDLE: all ReadyOut_SO = 0 and all encoder-side outputs = 0; if any ValidIn_SI is 1, select grant g by round-robin search starting at LastGrant+1 modulo NUM_REQ, clear BurstCnt to 0, then go to CLEAR if g != LastGrant or LastGrant is invalid, else go to SEND.
REQ-022 CLEAR: EncClear_SO = 1 for exactly one cycle, record LastGrant = g, then go to SEND unconditionally.
REQ-023 SEND: EncValid_SO = ValidIn_SI[g]; EncHypervector_DO = requester g slice (combinational mux); ReadyOut_SO[g] = EncReady_SI; all other ReadyOut_SO bits = 0.
REQ-024 SEND: on handshake (ValidIn_SI[g] & EncReady_SI), increment BurstCnt and go to WAIT; if ValidIn_SI[g] = 0, go to IDLE and release the grant.
REQ-025 WAIT: EncResultReady_SO = 1; when EncResultValid_SI = 1, register EncResult_DI into HypervectorOut_DO, register g into ChannelOut_DO, and go to DELIVER.
REQ-026 DELIVER: ValidOut_SO = 1; HypervectorOut_DO and ChannelOut_DO SHALL stay stable while ReadyIn_SI = 0.
REQ-027 DELIVER on ReadyIn_SI = 1: go to IDLE if BurstCnt = BURST_LEN or ValidIn_SI[g] = 0; otherwise go to SEND with the same grant and no clear.
REQ-028 At most one encoder transaction SHALL be outstanding; no new encoder input is issued before the previous result is delivered.
REQ-029 BurstCnt width SHALL be clog2(BURST_LEN+1); BurstCnt never exceeds BURST_LEN.
REQ-030 A grant SHALL switch to a different requester only through IDLE, and every switch SHALL pass through CLEAR, so n-gram history never mixes requesters.
REQ-031 Requesters not granted SHALL see ReadyOut_SO = 0 in every state.
REQ-032 Re-grant to the same requester after IDLE SHALL skip CLEAR, because LastGrant persists across IDLE.

Reset
REQ-033 On Reset_RI = 1: FSM = IDLE, LastGrant = invalid, BurstCnt = 0, HypervectorOut_DO = 0, ChannelOut_DO = 0.
REQ-034 During and immediately after reset, every output SHALL be 0, including ValidOut_SO, EncValid_SO, EncClear_SO and EncResultReady_SO.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction without emitting ValidOut_SO; the first grant after reset SHALL always pass through CLEAR.

Verification
REQ-036 First grant after reset: req0 valid, encoder always ready, result 1 cycle later -> EncClear_SO pulses 1 cycle, then EncValid_SO with req0 data, ValidOut_SO with ChannelOut_DO = 0.
REQ-037 Round-robin: all 3 requesters valid continuously, BURST_LEN = 4 -> 4 results on channel 0, then CLEAR, 4 on channel 1, then CLEAR, 4 on channel 2, then back to channel 0.
REQ-038 Early release: req1 drops valid after 2 items -> grant returns to IDLE after the 2nd delivery; with only req1 re-requesting, no EncClear_SO pulse occurs.
REQ-039 Backpressure: ReadyIn_SI held 0 for 5 cycles in DELIVER -> output data and channel stable, no EncValid_SO, EncReady_SI ignored.
REQ-040 Reset mid-WAIT -> all outputs 0 the same cycle; after release, the next grant asserts EncClear_SO.
